// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single request port of the direct-mapped line cache between
//   REQUESTERS masters. Round-robin grant, command held on the cache port
//   until cache_ready, one-cycle response pulse back to the winner, and
//   saturating access/hit counters for the statistics path.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/we/addr/wdata   per-master request, packed by master index
//   req_accept          one-hot pulse, request taken this cycle (from IDLE)
//   resp_valid          one-hot pulse, owner's operation completed
//   resp_data/resp_hit  response payload, qualified by resp_valid
//   cache_addr/read/write/write_data   command to the cache
//   cache_ready/hit/data               completion from the cache
//   busy                an operation is outstanding on the cache
//   stat_clear          synchronous clear of both counters
//   stat_access/stat_hit  saturating counters of completed ops / hits
module cache_arbiter #(
   parameter int unsigned REQUESTERS = 2,
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned STAT_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REQUESTERS-1:0]           req_valid,
   input  logic [REQUESTERS-1:0]           req_we,
   input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] req_wdata,
   output logic [REQUESTERS-1:0]           req_accept,
   output logic [REQUESTERS-1:0]           resp_valid,
   output logic [DATA_WIDTH-1:0]           resp_data,
   output logic                            resp_hit,
   output logic [ADDR_WIDTH-1:0]           cache_addr,
   output logic                            cache_read,
   output logic                            cache_write,
   output logic [DATA_WIDTH-1:0]           cache_write_data,
   input  logic                            cache_ready,
   input  logic                            cache_hit,
   input  logic [DATA_WIDTH-1:0]           cache_data,
   output logic                            busy,
   input  logic                            stat_clear,
   output logic [STAT_WIDTH-1:0]           stat_access,
   output logic [STAT_WIDTH-1:0]           stat_hit
);

   localparam int unsigned IDX_W = $clog2(REQUESTERS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t                 state;
   logic [IDX_W-1:0]       last_grant;
   logic [IDX_W-1:0]       owner;

   logic [IDX_W-1:0]       winner;
   logic                   found;
   logic                   sel_we;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   int unsigned            idx;

   // Round-robin search: scan last_grant+1 .. last_grant+REQUESTERS (mod N),
   // first valid master wins.
   always_comb begin
      winner    = '0;
      found     = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      idx       = 0;
      for (int unsigned k = 1; k <= REQUESTERS; k++) begin
         idx = (32'(last_grant) + k) % REQUESTERS;
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            winner    = idx[IDX_W-1:0];
            sel_we    = req_we[idx];
            sel_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // The accept pulse must coincide with the cycle the fields are sampled,
   // so it is decoded from the current state rather than registered.
   always_comb begin
      req_accept = '0;
      if (!rst && state == S_IDLE && found)
         req_accept[winner] = 1'b1;
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         last_grant       <= IDX_W'(REQUESTERS - 1);
         owner            <= '0;
         resp_valid       <= '0;
         resp_data        <= '0;
         resp_hit         <= 1'b0;
         cache_addr       <= '0;
         cache_read       <= 1'b0;
         cache_write      <= 1'b0;
         cache_write_data <= '0;
         stat_access      <= '0;
         stat_hit         <= '0;
      end else begin
         resp_valid <= '0;

         case (state)
            S_IDLE: begin
               if (found) begin
                  last_grant       <= winner;
                  owner            <= winner;
                  // The cache port registers are the latched command.
                  cache_addr       <= sel_addr;
                  cache_read       <= ~sel_we;
                  cache_write      <= sel_we;
                  cache_write_data <= sel_wdata;
                  state            <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (cache_ready) begin
                  resp_data          <= cache_write ? '0 : cache_data;
                  resp_hit           <= cache_hit;
                  resp_valid[owner]  <= 1'b1;
                  cache_addr         <= '0;
                  cache_read         <= 1'b0;
                  cache_write        <= 1'b0;
                  cache_write_data   <= '0;
                  state              <= S_RESP;
               end
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase

         // Clear wins over the RESP-cycle increment.
         if (stat_clear) begin
            stat_access <= '0;
            stat_hit    <= '0;
         end else if (state == S_RESP) begin
            if (stat_access != '1)
               stat_access <= stat_access + STAT_WIDTH'(1);
            if (resp_hit && stat_hit != '1)
               stat_hit <= stat_hit + STAT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 14;
   localparam int unsigned DW   = 10;
   localparam int unsigned SW   = 4;   // narrow counters so saturation is reachable
   localparam int          MISS_EXTRA = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid, req_we;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ-1:0]      req_accept, resp_valid;
   logic [DW-1:0]        resp_data;
   logic                 resp_hit;
   logic [AW-1:0]        cache_addr;
   logic                 cache_read, cache_write;
   logic [DW-1:0]        cache_write_data;
   logic                 cache_ready, cache_hit;
   logic [DW-1:0]        cache_data;
   logic                 busy, stat_clear;
   logic [SW-1:0]        stat_access, stat_hit;

   always #5 clk = ~clk;

   cache_arbiter #(
      .REQUESTERS(NREQ),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .STAT_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_accept(req_accept), .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
      .cache_addr(cache_addr), .cache_read(cache_read), .cache_write(cache_write),
      .cache_write_data(cache_write_data), .cache_ready(cache_ready), .cache_hit(cache_hit),
      .cache_data(cache_data), .busy(busy), .stat_clear(stat_clear),
      .stat_access(stat_access), .stat_hit(stat_hit)
   );

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- behavioural cache ----------------
   bit [DW-1:0] mem [0:(1<<AW)-1];
   bit          present [0:(1<<AW)-1];
   int          cst, cnt;
   logic        ready_r, hit_r, spur;
   logic [DW-1:0] data_r;

   assign cache_ready = ready_r | spur;
   assign cache_hit   = hit_r;
   assign cache_data  = data_r;

   always @(posedge clk) begin
      if (rst) begin
         cst     <= 0;
         cnt     <= 0;
         ready_r <= 1'b0;
         hit_r   <= 1'b0;
         data_r  <= '0;
         present[14'h0041] <= 1'b1;
         mem[14'h0041]     <= 10'h155;
         mem[14'h3FE0]     <= 10'h0C3;
      end else begin
         ready_r <= 1'b0;
         case (cst)
            0: if (cache_read || cache_write) begin
                  if (present[cache_addr]) begin
                     ready_r <= 1'b1;
                     hit_r   <= 1'b1;
                     data_r  <= cache_write ? 10'h3FF : mem[cache_addr];
                     if (cache_write) mem[cache_addr] <= cache_write_data;
                     cst <= 2;
                  end else begin
                     cnt <= MISS_EXTRA;
                     cst <= 1;
                  end
               end
            1: if (cnt == 1) begin
                  ready_r <= 1'b1;
                  hit_r   <= 1'b0;
                  present[cache_addr] <= 1'b1;
                  data_r  <= cache_write ? 10'h3FF : mem[cache_addr];
                  if (cache_write) mem[cache_addr] <= cache_write_data;
                  cst <= 2;
               end else begin
                  cnt <= cnt - 1;
               end
            default: cst <= 0;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          m;
      logic [DW-1:0] data;
      logic        hit;
      int          lat;
   } resp_t;

   resp_t resp_q[$];
   int    acc_q[$];

   task automatic exp_op(input int m, input logic [DW-1:0] d, input logic h, input int lat);
      resp_t e;
      e.m = m; e.data = d; e.hit = h; e.lat = lat;
      acc_q.push_back(m);
      resp_q.push_back(e);
   endtask

   int            acc_cycle [NREQ];
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic          cur_we;

   always @(negedge clk) begin
      if (!rst) begin
         if (req_accept != '0) begin
            check("accept_while_busy", busy, 0);
            check("accept_onehot", $countones(req_accept), 1);
            if (acc_q.size() == 0) begin
               check("unexpected_accept", req_accept, 0);
            end else begin
               int m;
               m = acc_q.pop_front();
               check("accept_index", req_accept, 32'd1 << m);
            end
            for (int k = 0; k < NREQ; k++)
               if (req_accept[k]) begin
                  acc_cycle[k] = cycle;
                  cur_addr     = req_addr[k*AW +: AW];
                  cur_wdata    = req_wdata[k*DW +: DW];
                  cur_we       = req_we[k];
               end
         end
         if (busy && resp_valid == '0) begin
            check("issue_addr", cache_addr, cur_addr);
            check("issue_rw", {cache_read, cache_write}, {~cur_we, cur_we});
            if (cur_we) check("issue_wdata", cache_write_data, cur_wdata);
         end
         if (!busy)
            check("idle_cmd", {cache_read, cache_write, cache_addr, cache_write_data}, 0);
         if (resp_valid != '0) begin
            check("resp_cmd_low", {cache_read, cache_write}, 0);
            if (resp_q.size() == 0) begin
               check("unexpected_resp", resp_valid, 0);
            end else begin
               resp_t e;
               e = resp_q.pop_front();
               check("resp_owner", resp_valid, 32'd1 << e.m);
               check("resp_data", resp_data, e.data);
               check("resp_hit", resp_hit, e.hit);
               if (e.lat > 0) check("resp_latency", cycle - acc_cycle[e.m], e.lat);
            end
         end
      end
   end

   // ---------------- driver ----------------
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t q0[$];
   txn_t q1[$];
   bit   outst [NREQ];
   bit   clr_on_resp;

   task automatic put(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      if (m == 0) q0.push_back(t); else q1.push_back(t);
   endtask

   task automatic load();
      txn_t t;
      for (int k = 0; k < NREQ; k++) begin
         if (!req_valid[k] && !outst[k] && ((k == 0) ? q0.size() : q1.size()) > 0) begin
            t = (k == 0) ? q0.pop_front() : q1.pop_front();
            req_we[k]              = t.we;
            req_addr[k*AW +: AW]   = t.addr;
            req_wdata[k*DW +: DW]  = t.wdata;
            req_valid[k]           = 1'b1;
         end
      end
   endtask

   task automatic tick();
      logic [NREQ-1:0] a, r;
      @(negedge clk);
      a = req_accept;
      r = resp_valid;
      if (clr_on_resp && r != '0) stat_clear = 1'b1;
      @(posedge clk);
      #1;
      stat_clear = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (a[k]) begin req_valid[k] = 1'b0; outst[k] = 1'b1; end
         if (r[k]) outst[k] = 1'b0;
      end
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      forever begin
         load();
         if (q0.size() == 0 && q1.size() == 0 && req_valid == '0 && !outst[0] && !outst[1]) break;
         if (n >= budget) begin
            check("run_timeout", n, 0);
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic check_stats(input string name, input int acc, input int hit);
      check({name, "_access"}, stat_access, acc);
      check({name, "_hit"}, stat_hit, hit);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      stat_clear = 1'b0; spur = 1'b0; clr_on_resp = 1'b0;
      outst[0] = 1'b0; outst[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      check("rst_busy", busy, 0);
      check("rst_accept", req_accept, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_cache_cmd", {cache_read, cache_write, cache_addr, cache_write_data}, 0);
      check_stats("rst", 0, 0);

      // cold read miss by master 1
      put(1, 1'b0, 14'h3FE0, '0); exp_op(1, 10'h0C3, 1'b0, 0);
      run(40);
      check_stats("miss", 1, 0);

      // read hit by master 0
      put(0, 1'b0, 14'h0041, '0); exp_op(0, 10'h155, 1'b1, 3);
      run(40);
      check_stats("hit", 2, 1);

      // write then read of the same address
      put(0, 1'b1, 14'h0100, 10'h2AA); exp_op(0, 10'h000, 1'b0, 0);
      run(40);
      put(1, 1'b0, 14'h0100, '0); exp_op(1, 10'h2AA, 1'b1, 3);
      run(40);
      check_stats("wr_rd", 4, 2);

      // contention: both masters always valid, writes to distinct lines
      put(0, 1'b1, 14'h0200, 10'h011);
      put(0, 1'b1, 14'h0201, 10'h022);
      put(1, 1'b1, 14'h0300, 10'h033);
      put(1, 1'b1, 14'h0301, 10'h044);
      exp_op(0, 10'h000, 1'b0, 0);
      exp_op(1, 10'h000, 1'b0, 0);
      exp_op(0, 10'h000, 1'b0, 0);
      exp_op(1, 10'h000, 1'b0, 0);
      run(120);
      check_stats("contend", 8, 2);

      // stray ready while idle must be ignored
      spur = 1'b1;
      repeat (3) tick();
      spur = 1'b0;
      tick();
      check("spur_busy", busy, 0);
      check_stats("spur", 8, 2);

      // idle clear, then drive counters to 0xE
      stat_clear = 1'b1;
      tick();
      check_stats("clear_idle", 0, 0);
      for (int i = 0; i < 14; i++) begin
         put(0, 1'b0, 14'h0041, '0); exp_op(0, 10'h155, 1'b1, 3);
      end
      run(14 * 4 + 20);
      check_stats("preset", 14, 14);
      for (int i = 0; i < 3; i++) begin
         put(0, 1'b0, 14'h0041, '0); exp_op(0, 10'h155, 1'b1, 3);
      end
      run(3 * 4 + 20);
      check_stats("saturate", 15, 15);

      // clear coincident with the RESP-cycle increment
      clr_on_resp = 1'b1;
      put(0, 1'b0, 14'h0041, '0); exp_op(0, 10'h155, 1'b1, 3);
      run(40);
      clr_on_resp = 1'b0;
      check_stats("clear_resp", 0, 0);

      // reset during a miss fill, issued by master 0 (last_grant becomes 0)
      put(0, 1'b0, 14'h1234, '0);
      acc_q.push_back(0);
      load();
      n = 0;
      while (!outst[0] && n < 10) begin tick(); n++; end
      check("abort_accepted", outst[0], 1);
      tick();
      tick();
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      outst[0] = 1'b0;
      check("abort_busy_after", busy, 0);
      check("abort_resp_valid", resp_valid, 0);
      check_stats("abort", 0, 0);
      repeat (8) tick();
      check("abort_still_idle", busy, 0);

      // both request together: master 0 must win after reset
      put(0, 1'b0, 14'h0041, '0);
      put(1, 1'b0, 14'h0041, '0);
      exp_op(0, 10'h155, 1'b1, 3);
      exp_op(1, 10'h155, 1'b1, 3);
      run(40);
      check_stats("post_rst", 2, 2);

      check("queues_drained", acc_q.size() + resp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single request port of the direct-mapped line cache between `REQUESTERS` independent masters, such as the instruction fetch and the data load/store units. Requests are granted round-robin. The winning command is held stable on the cache port until the cache signals `ready`, and the result is returned to the winner as a one-cycle response. The block also keeps saturating access and hit counters for the debug/statistics path. It sits between the masters and the cache; the cache's RAM side is not touched.

## Interface
- `REQUESTERS`, 2 — number of masters, ≥2.
- `ADDR_WIDTH`, 14 — word address width; must match the cache.
- `DATA_WIDTH`, 10 — data word width; must match the cache.
- `STAT_WIDTH`, 16 — width of the statistics counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  REQUESTERS  per-master request pending.
- `req_we`  in  REQUESTERS  1 = write, 0 = read.
- `req_addr`  in  REQUESTERS×ADDR_WIDTH  packed; master i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  REQUESTERS×DATA_WIDTH  packed; same layout.
- `req_accept`  out  REQUESTERS  one-hot, one-cycle pulse; the request is taken this cycle.
- `resp_valid`  out  REQUESTERS  one-hot, one-cycle pulse; the owner's operation has completed.
- `resp_data`  out  DATA_WIDTH  read data; qualified by `resp_valid`.
- `resp_hit`  out  1  completed access was a cache hit; qualified by `resp_valid`.
- `cache_addr`  out  ADDR_WIDTH  to cache `addr`.
- `cache_read`  out  1  to cache `read`.
- `cache_write`  out  1  to cache `write`.
- `cache_write_data`  out  DATA_WIDTH  to cache `write_data`.
- `cache_ready`  in  1  from cache `ready`.
- `cache_hit`  in  1  from cache `hit`.
- `cache_data`  in  DATA_WIDTH  from cache `data`; valid only while `cache_ready` and a read is in progress.
- `busy`  out  1  an operation is outstanding on the cache.
- `stat_clear`  in  1  synchronous clear of both counters.
- `stat_access`  out  STAT_WIDTH  completed operations.
- `stat_hit`  out  STAT_WIDTH  completed operations with a hit.

## Operation
- FSM states:
  - IDLE: no command is driven.
  - ISSUE: the latched command is driven to the cache.
  - RESP: the response cycle; the cache is back in its idle state.
- IDLE:
  - If any `req_valid` is set, pick a winner by round-robin starting at `last_grant+1` (mod REQUESTERS).
  - Pulse `req_accept[winner]` in the same cycle.
  - Latch addr, we, wdata and the winner index; update `last_grant` to the winner.
  - Go to ISSUE.
- ISSUE:
  - Drive `cache_addr` = latched addr, `cache_read` = ~we, `cache_write` = we, `cache_write_data` = latched wdata.
  - Hold all of them constant until `cache_ready` = 1.
  - On `cache_ready`: capture `resp_data` (= `cache_data` for a read, 0 for a write) and `resp_hit` (= `cache_hit`), then go to RESP.
- RESP:
  - `resp_valid[owner]` = 1; `cache_read` = `cache_write` = 0.
  - Go to IDLE. This guarantees one command-free cycle, so the cache never re-triggers on a held command.
- Outside ISSUE: `cache_read` = `cache_write` = 0, `cache_addr` = 0, `cache_write_data` = 0.
- Request fields are sampled only in the accept cycle. A master may drop `req_valid` before accept, in which case no accept occurs. It must not raise a new request until it has seen its `resp_valid`.
- `last_grant` resets to REQUESTERS-1, so master 0 has first priority.
- Counters:
  - In the RESP cycle, `stat_access` increments; `stat_hit` also increments if `resp_hit` = 1.
  - Both saturate at all-ones.
  - `stat_clear` takes precedence over an increment in the same cycle.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - state IDLE; `req_accept`, `resp_valid`, `resp_hit`, `busy` = 0.
  - `resp_data`, `cache_addr`, `cache_write_data` = 0; `cache_read`, `cache_write` = 0.
  - Counters 0; `last_grant` = REQUESTERS-1.
- `rst` during ISSUE abandons the operation: no `resp_valid` is produced and the counters are cleared. The cache shares `rst`.
- Hit latency: accept at cycle T, cache sees the command at T+1, `cache_ready` at T+2, `resp_valid` at T+3.
- Miss latency: T+3 plus the cache's fill and writeback cycles. The arbiter imposes no timeout.
- Back-to-back: the next accept can occur in the cycle after RESP, giving a minimum issue interval of 4 cycles.
- `cache_ready` seen outside ISSUE is ignored.

## Test plan
- Single read hit: master 0 reads addr 0x0041, which is preloaded with 0x155. Expect `req_accept[0]` at T, `resp_valid[0]` at T+3, `resp_data` = 0x155, `resp_hit` = 1, `stat_access` = `stat_hit` = 1.
- Cold read miss: master 1 reads addr 0x3FE0 after reset. Expect `cache_read` held constant through the entire fill until `cache_ready`, then `resp_hit` = 0 and `stat_hit` unchanged.
- Contention: both masters are valid every cycle with writes to different addresses. Expect accepts alternating 0,1,0,1, exactly one outstanding operation at a time, and `cache_read`/`cache_write` low in every RESP cycle.
- Write then read: master 0 writes 0x2AA to addr 0x0100, then master 1 reads addr 0x0100. Expect `resp_data` = 0x2AA.
- Saturation and clear: preset both counters to 0xFFFE and perform 3 hits. Expect both counters at 0xFFFF. Then assert `stat_clear` in a RESP cycle and expect both counters at 0.
- Reset mid-operation: assert `rst` during a miss fill. Expect `busy` = 0, no `resp_valid`, and the next request accepted with master 0 at priority.
